// File: rtl/distram_fifo64_if.sv
// Handshake bundle for distram_fifo64: write side, flush, and the
// valid/ready output port. The FIFO uses the slave view; a source/consumer
// (or a testbench) uses the master view.
interface distram_fifo64_if #(
  parameter int WIDTH = 8
);
  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [6:0]       level;

  modport master (
    output flush, wr_en, wr_data, out_ready,
    input  full, overflow, out_valid, out_data, level
  );

  modport slave (
    input  flush, wr_en, wr_data, out_ready,
    output full, overflow, out_valid, out_data, level
  );
endinterface

// File: rtl/distram_fifo64.sv
// 64-deep synchronous FIFO built from WIDTH 64x1 dual-port distributed RAMs
// (synchronous write port, asynchronous read port) followed by a one-word
// output register. The output register gives first-word-fall-through with a
// valid/ready handshake, so the total capacity is 65 words.
module distram_fifo64 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  distram_fifo64_if.slave  bus
);
  localparam int DEPTH = 64;

  logic [5:0]       wr_ptr;
  logic [5:0]       rd_ptr;
  logic [6:0]       ram_count;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             overflow_q;

  logic             full;
  logic             ram_empty;
  logic             wr_accept;
  logic             pop;
  logic             load;
  logic [WIDTH-1:0] rd_word;
  logic [6:0]       count_next;

  assign full      = (ram_count == 7'd64);
  assign ram_empty = (ram_count == 7'd0);

  // A write during flush is discarded, so it must not touch the RAM either.
  assign wr_accept = bus.wr_en && !full && !bus.flush;
  assign pop       = out_valid_q && bus.out_ready;
  // Refill the output register whenever it is empty or being emptied now.
  assign load      = !ram_empty && (!out_valid_q || pop);

  assign count_next = ram_count + {6'd0, wr_accept} - {6'd0, load};

  // One 64x1 distributed RAM per data bit: write at wr_ptr, async read at
  // rd_ptr. A load at rd_ptr == wr_ptr only happens when the RAM is full and
  // the write is then blocked, so the old word is always the right answer.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [DEPTH-1:0] mem;

      // Write port A; contents deliberately survive reset and flush.
      always_ff @(posedge clk) begin
        if (wr_accept) begin
          mem[wr_ptr] <= bus.wr_data[gi];
        end
      end

      assign rd_word[gi] = mem[rd_ptr];
    end
  endgenerate

  // Pointers and RAM occupancy; flush outranks any write or load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 6'd0;
      rd_ptr    <= 6'd0;
      ram_count <= 7'd0;
    end else if (bus.flush) begin
      wr_ptr    <= 6'd0;
      rd_ptr    <= 6'd0;
      ram_count <= 7'd0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 6'd1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 6'd1;
      end
      ram_count <= count_next;
    end
  end

  // Output register: out_data only changes on a load, so it holds steady
  // while the consumer stalls. Flush drops the valid flag but keeps the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rd_word;
    end else if (pop) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky overflow: any write attempt while full, even if a slot frees
  // up in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && full) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.full      = full;
  assign bus.overflow  = overflow_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.level     = ram_count + {6'd0, out_valid_q};
endmodule

// File: tb/tb_distram_fifo64.sv
// Self-checking bench for distram_fifo64. A negedge monitor keeps a
// cycle model (RAM occupancy, output-valid, overflow) plus a data queue:
// accepted writes are pushed, handshaken outputs are popped and compared.
// The initial block runs the directed steps and adds point checks.
module tb_distram_fifo64;
  logic clk = 1'b0;
  logic rst_n;

  distram_fifo64_if #(.WIDTH(8)) bus ();

  distram_fifo64 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int pops     = 0;

  // Reference state
  logic [7:0] q[$];
  int         m_ram = 0;
  logic       m_ov  = 1'b0;
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT state to the model, then advance the model by the
  // inputs that will be sampled at the coming rising edge.
  always @(negedge clk) begin
    logic p, ld, wa;
    if (!rst_n) begin
      q.delete();
      m_ram = 0;
      m_ov  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      check("mon_out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("mon_level", 32'(bus.level), 32'(m_ram + int'(m_ov)));
      check("mon_full", 32'(bus.full), 32'(m_ram == 64));
      check("mon_overflow", 32'(bus.overflow), 32'(m_ovf));
      if (m_ov && q.size() > 0) begin
        check("mon_out_data", 32'(bus.out_data), 32'(q[0]));
      end
      if (bus.flush) begin
        q.delete();
        m_ram = 0;
        m_ov  = 1'b0;
        m_ovf = 1'b0;
      end else begin
        p  = m_ov && bus.out_ready;
        ld = (m_ram != 0) && (!m_ov || p);
        wa = bus.wr_en && (m_ram != 64);
        if (bus.wr_en && m_ram == 64) m_ovf = 1'b1;
        if (p) begin
          void'(q.pop_front());
          pops++;
        end
        if (wa) q.push_back(bus.wr_data);
        m_ram = m_ram + int'(wa) - int'(ld);
        if (ld) m_ov = 1'b1;
        else if (p) m_ov = 1'b0;
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single word, two-cycle fall-through latency
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    check("t1_valid_after_1", 32'(bus.out_valid), 32'd0);
    tick();
    check("t1_valid_after_2", 32'(bus.out_valid), 32'd1);
    check("t1_data", 32'(bus.out_data), 32'hA5);
    check("t1_level", 32'(bus.level), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("t1_pop_valid", 32'(bus.out_valid), 32'd0);
    check("t1_pop_level", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;

    // 2: fill to 65, overflow on the 66th, drain in order
    for (int i = 0; i <= 64; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      tick();
    end
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_level65", 32'(bus.level), 32'd65);
    check("t2_no_ovf_yet", 32'(bus.overflow), 32'd0);
    for (int i = 65; i <= 127; i++) begin
      bus.wr_data = 8'(i);
      tick();
      if (i == 65) check("t2_ovf", 32'(bus.overflow), 32'd1);
    end
    bus.wr_en     = 1'b0;
    pops          = 0;
    bus.out_ready = 1'b1;
    repeat (66) tick();
    check("t2_pops", 32'(pops), 32'd65);
    check("t2_drained", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("t2_flush_ovf", 32'(bus.overflow), 32'd0);

    // 3: streaming with wrap, steady level
    pops = 0;
    for (int c = 0; c < 200; c++) begin
      bus.wr_en     = 1'b1;
      bus.wr_data   = 8'(c);
      bus.out_ready = 1'b1;
      tick();
      if (c == 100) check("t3_level_mid", 32'(bus.level), 32'd2);
    end
    check("t3_level_end", 32'(bus.level), 32'd2);
    check("t3_valid_end", 32'(bus.out_valid), 32'd1);
    check("t3_ovf", 32'(bus.overflow), 32'd0);
    bus.wr_en = 1'b0;
    repeat (4) tick();
    check("t3_pops", 32'(pops), 32'd200);
    check("t3_level_drained", 32'(bus.level), 32'd0);

    // 4: stalled consumer while writing
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h30 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    tick();
    check("t4_level3", 32'(bus.level), 32'd3);
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    check("t4_head", 32'(bus.out_data), 32'h30);
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h40 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    check("t4_level13", 32'(bus.level), 32'd13);
    check("t4_head_stable", 32'(bus.out_data), 32'h30);

    // 5: flush with a simultaneous write at level 20
    for (int i = 0; i < 7; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h50 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    tick();
    check("t5_level20", 32'(bus.level), 32'd20);
    bus.flush   = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    check("t5_level", 32'(bus.level), 32'd0);
    check("t5_valid", 32'(bus.out_valid), 32'd0);
    check("t5_ovf", 32'(bus.overflow), 32'd0);
    check("t5_full", 32'(bus.full), 32'd0);
    tick();
    tick();
    check("t5_write_dropped", 32'(bus.level), 32'd0);
    check("t5_valid_later", 32'(bus.out_valid), 32'd0);

    // 6: asynchronous reset mid-stream, then restart from address 0
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h60 + i);
      tick();
    end
    check("t6_pre_level", 32'(bus.level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(bus.out_valid), 32'd0);
    check("t6_async_level", 32'(bus.level), 32'd0);
    check("t6_async_full", 32'(bus.full), 32'd0);
    check("t6_async_ovf", 32'(bus.overflow), 32'd0);
    bus.wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    pops  = 0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h71 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (4) tick();
    check("t6_pops", 32'(pops), 32'd3);
    check("t6_level", 32'(bus.level), 32'd0);
    check("t6_last_data", 32'(bus.out_data), 32'h73);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
